// File: rtl/rs232_word_buffer.sv
// Byte FIFO between the RS232 controller's serial word ports: deserialises received
// words into the FIFO and, when echo is enabled, serialises them back with a paced gap.
module rs232_word_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_TICKS  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_rs232_en,
  input  logic                  new_word,
  input  logic                  data_rs232_in,
  output logic                  send_word,
  output logic                  data_rs232_out,
  input  logic                  echo_en,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int GAP_W = $clog2(GAP_TICKS + 1) + 1;

  localparam logic [1:0] D_IDLE  = 2'd0;
  localparam logic [1:0] D_SKIP  = 2'd1;
  localparam logic [1:0] D_SHIFT = 2'd2;
  localparam logic [1:0] D_WAIT  = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]            dstate_q, dstate_d;
  logic [2:0]            dbit_q, dbit_d;
  logic [7:0]            dsreg_q, dsreg_d;
  logic [1:0]            sstate_q, sstate_d;
  logic [3:0]            sbit_q, sbit_d;
  logic [7:0]            ssreg_q, ssreg_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  send_word_q, send_word_d;
  logic                  dout_q, dout_d;
  logic                  ovf_q, ovf_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            mem_q [DEPTH];

  logic push, push_ok, pop;

  assign full           = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty          = (count_q == '0);
  assign count          = count_q;
  assign send_word      = send_word_q;
  assign data_rs232_out = dout_q;
  assign overflow       = ovf_q;

  // Deserialiser: one no-data cycle, then 8 bits MSB first.
  always_comb begin
    dstate_d = dstate_q;
    dbit_d   = dbit_q;
    dsreg_d  = dsreg_q;
    push     = 1'b0;
    case (dstate_q)
      D_IDLE: begin
        if (new_word) begin
          dstate_d = D_SKIP;
          dbit_d   = 3'd0;
        end
      end
      D_SKIP, D_SHIFT: begin
        if (!new_word) begin
          dstate_d = D_IDLE;
        end else begin
          dsreg_d = {dsreg_q[6:0], data_rs232_in};
          if (dbit_q == 3'd7) begin
            push     = 1'b1;
            dstate_d = D_WAIT;
          end else begin
            dbit_d   = dbit_q + 3'd1;
            dstate_d = D_SHIFT;
          end
        end
      end
      D_WAIT: begin
        if (!new_word) dstate_d = D_IDLE;
      end
      default: dstate_d = D_IDLE;
    endcase
  end

  // The pop is committed in the cycle send_word is high, so count drops one cycle later.
  assign pop     = send_word_q;
  assign push_ok = push && !full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = push && full;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  // Serialiser: S_SEND spans the send_word cycle plus the 8 bit cycles.
  always_comb begin
    sstate_d    = sstate_q;
    sbit_d      = sbit_q;
    ssreg_d     = ssreg_q;
    gap_d       = gap_q;
    send_word_d = 1'b0;
    dout_d      = 1'b0;
    case (sstate_q)
      S_IDLE: begin
        if (echo_en && !empty) begin
          ssreg_d     = mem_q[rd_ptr_q];
          send_word_d = 1'b1;
          sbit_d      = 4'd0;
          sstate_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (sbit_q == 4'd8) begin
          sstate_d = S_GAP;
          gap_d    = '0;
        end else begin
          dout_d  = ssreg_q[7];
          ssreg_d = {ssreg_q[6:0], 1'b0};
          sbit_d  = sbit_q + 4'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_TICKS)) sstate_d = S_IDLE;
        else if (clk_rs232_en)          gap_d    = gap_q + 1'b1;
      end
      default: sstate_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstate_q    <= D_IDLE;
      dbit_q      <= '0;
      dsreg_q     <= '0;
      sstate_q    <= S_IDLE;
      sbit_q      <= '0;
      ssreg_q     <= '0;
      gap_q       <= '0;
      send_word_q <= 1'b0;
      dout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      dstate_q    <= dstate_d;
      dbit_q      <= dbit_d;
      dsreg_q     <= dsreg_d;
      sstate_q    <= sstate_d;
      sbit_q      <= sbit_d;
      ssreg_q     <= ssreg_d;
      gap_q       <= gap_d;
      send_word_q <= send_word_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= dsreg_d;
  end

endmodule
